// File: rtl/updi_frame_sequencer.sv
// UPDI transmit frame sequencer: SYNCH, opcode and data bytes into a TX FIFO, with optional ACK waits.
// Define UPDI_FRAME_SEQ_ACK_TIMEOUT_EN to bound each ACK wait to ACK_TIMEOUT cycles.
module updi_frame_sequencer #(
    parameter int MAX_DATA_SIZE  = 16,
    parameter int DATA_ADDR_BITS = $clog2(MAX_DATA_SIZE),
    parameter int ACK_TIMEOUT    = 1024
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic                          skip_synch,
    input  logic                          abort,
    input  logic [7:0]                    opcode,
    input  logic [8*MAX_DATA_SIZE-1:0]    data,
    input  logic [DATA_ADDR_BITS:0]       data_len,
    input  logic [MAX_DATA_SIZE-1:0]      wait_ack_after,
    input  logic                          ack_received,
    output logic                          ready,
    output logic                          done,
    output logic                          error,
    output logic                          timeout,
    output logic                          waiting_for_ack,
    output logic [DATA_ADDR_BITS+1:0]     bytes_sent,
    output logic [7:0]                    fifo_data,
    output logic                          fifo_wr_en,
    input  logic                          fifo_full
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNCH,
        ST_OPCODE,
        ST_DATA,
        ST_WAIT_ACK
    } state_t;

    localparam logic [DATA_ADDR_BITS:0]   MAX_LEN   = (DATA_ADDR_BITS+1)'(MAX_DATA_SIZE);
    localparam logic [DATA_ADDR_BITS:0]   LEN_ONE   = (DATA_ADDR_BITS+1)'(1);
    localparam logic [DATA_ADDR_BITS-1:0] IDX_ONE   = (DATA_ADDR_BITS)'(1);
    localparam logic [DATA_ADDR_BITS+1:0] COUNT_ONE = (DATA_ADDR_BITS+2)'(1);

    state_t                        state, state_nxt;
    logic [DATA_ADDR_BITS-1:0]     index, index_nxt;
    logic [7:0]                    opcode_q;
    logic [8*MAX_DATA_SIZE-1:0]    data_q;
    logic [DATA_ADDR_BITS:0]       len_q;
    logic [MAX_DATA_SIZE-1:0]      mask_q;
    logic [DATA_ADDR_BITS:0]       len_clamped;
    logic [DATA_ADDR_BITS+1:0]     bytes_sent_q;
    logic                          ready_q, done_q, error_q, timeout_q;
    logic                          done_nxt, error_nxt, timeout_nxt;
    logic                          accept;
    logic                          is_last;
    logic                          ack_expired;

    assign accept      = (state == ST_IDLE) && start && ready_q;
    assign len_clamped = (data_len > MAX_LEN) ? MAX_LEN : data_len;
    assign is_last     = ({1'b0, index} == (len_q - LEN_ONE));

`ifdef UPDI_FRAME_SEQ_ACK_TIMEOUT_EN
    localparam int TO_BITS = $clog2(ACK_TIMEOUT + 1);
    localparam logic [TO_BITS-1:0] TO_LAST = TO_BITS'(ACK_TIMEOUT - 1);
    localparam logic [TO_BITS-1:0] TO_ONE  = TO_BITS'(1);

    logic [TO_BITS-1:0] ack_cnt;

    // Counter sits at zero outside WAIT_ACK, so every wait starts counting fresh.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_cnt <= '0;
        end else if (state != ST_WAIT_ACK) begin
            ack_cnt <= '0;
        end else begin
            ack_cnt <= ack_cnt + TO_ONE;
        end
    end

    assign ack_expired = (state == ST_WAIT_ACK) && (ack_cnt == TO_LAST);
`else
    assign ack_expired = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            index        <= '0;
            ready_q      <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            timeout_q    <= 1'b0;
            bytes_sent_q <= '0;
        end else begin
            state     <= state_nxt;
            index     <= index_nxt;
            ready_q   <= (state_nxt == ST_IDLE);
            done_q    <= done_nxt;
            error_q   <= error_nxt;
            timeout_q <= timeout_nxt;
            if (accept) begin
                bytes_sent_q <= '0;
            end else if (fifo_wr_en && !fifo_full) begin
                bytes_sent_q <= bytes_sent_q + COUNT_ONE;
            end
        end
    end

    // Request snapshot: the frame only ever reads these copies once started.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opcode_q <= '0;
            data_q   <= '0;
            len_q    <= '0;
            mask_q   <= '0;
        end else if (accept) begin
            opcode_q <= opcode;
            data_q   <= data;
            len_q    <= len_clamped;
            mask_q   <= wait_ack_after;
        end
    end

    always_comb begin
        state_nxt   = state;
        index_nxt   = index;
        done_nxt    = 1'b0;
        error_nxt   = 1'b0;
        timeout_nxt = 1'b0;
        fifo_data   = 8'h00;
        fifo_wr_en  = 1'b0;

        case (state)
            ST_SYNCH: begin
                fifo_data  = 8'h55;
                fifo_wr_en = 1'b1;
            end
            ST_OPCODE: begin
                fifo_data  = opcode_q;
                fifo_wr_en = 1'b1;
            end
            ST_DATA: begin
                fifo_data  = data_q[{index, 3'b000} +: 8];
                fifo_wr_en = 1'b1;
            end
            default: ;
        endcase

        // Abort suppresses the write of the byte currently on offer.
        if (abort && (state != ST_IDLE)) begin
            fifo_wr_en = 1'b0;
            state_nxt  = ST_IDLE;
            index_nxt  = '0;
            error_nxt  = 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state_nxt = skip_synch ? ST_OPCODE : ST_SYNCH;
                        index_nxt = '0;
                    end
                end
                ST_SYNCH: begin
                    if (!fifo_full) begin
                        state_nxt = ST_OPCODE;
                    end
                end
                ST_OPCODE: begin
                    if (!fifo_full) begin
                        if (len_q != '0) begin
                            state_nxt = ST_DATA;
                            index_nxt = '0;
                        end else begin
                            state_nxt = ST_IDLE;
                            done_nxt  = 1'b1;
                        end
                    end
                end
                ST_DATA: begin
                    if (!fifo_full) begin
                        if (mask_q[index]) begin
                            state_nxt = ST_WAIT_ACK;
                        end else if (is_last) begin
                            state_nxt = ST_IDLE;
                            done_nxt  = 1'b1;
                        end else begin
                            index_nxt = index + IDX_ONE;
                        end
                    end
                end
                ST_WAIT_ACK: begin
                    if (ack_received) begin
                        if (is_last) begin
                            state_nxt = ST_IDLE;
                            done_nxt  = 1'b1;
                        end else begin
                            state_nxt = ST_DATA;
                            index_nxt = index + IDX_ONE;
                        end
                    end else if (ack_expired) begin
                        state_nxt   = ST_IDLE;
                        error_nxt   = 1'b1;
                        timeout_nxt = 1'b1;
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    assign ready           = ready_q;
    assign done            = done_q;
    assign error           = error_q;
    assign timeout         = timeout_q;
    assign waiting_for_ack = (state == ST_WAIT_ACK);
    assign bytes_sent      = bytes_sent_q;

endmodule

// File: tb/tb_updi_frame_sequencer.sv
// Randomized bench for updi_frame_sequencer: each frame is predicted as an ordered byte list plus ACK waits.
module tb_updi_frame_sequencer;

    localparam int MAX = 16;
    localparam int AB  = $clog2(MAX);
    localparam int TO  = 8;
`ifdef UPDI_FRAME_SEQ_ACK_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst_n;
    logic               start, skip_synch, abort, ack_received, fifo_full;
    logic [7:0]         opcode;
    logic [8*MAX-1:0]   data;
    logic [AB:0]        data_len;
    logic [MAX-1:0]     wait_ack_after;
    logic               ready, done, error, timeout, waiting_for_ack, fifo_wr_en;
    logic [AB+1:0]      bytes_sent;
    logic [7:0]         fifo_data;

    int checks = 0;
    int errors = 0;

    updi_frame_sequencer #(
        .MAX_DATA_SIZE (MAX),
        .ACK_TIMEOUT   (TO)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .skip_synch      (skip_synch),
        .abort           (abort),
        .opcode          (opcode),
        .data            (data),
        .data_len        (data_len),
        .wait_ack_after  (wait_ack_after),
        .ack_received    (ack_received),
        .ready           (ready),
        .done            (done),
        .error           (error),
        .timeout         (timeout),
        .waiting_for_ack (waiting_for_ack),
        .bytes_sent      (bytes_sent),
        .fifo_data       (fifo_data),
        .fifo_wr_en      (fifo_wr_en),
        .fifo_full       (fifo_full)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_ready"}, ready, 0);
        checkOutput({tag, "_done"}, done, 0);
        checkOutput({tag, "_error"}, error, 0);
        checkOutput({tag, "_timeout"}, timeout, 0);
        checkOutput({tag, "_waiting"}, waiting_for_ack, 0);
        checkOutput({tag, "_bytes"}, bytes_sent, 0);
        checkOutput({tag, "_wr_en"}, fifo_wr_en, 0);
    endtask

    // Runs one frame; min/max delay give the ACK latency per masked byte (in WAIT_ACK cycles).
    task automatic applyStimulus(input bit skip, input logic [7:0] op, input logic [8*MAX-1:0] d,
                                 input logic [AB:0] len, input logic [MAX-1:0] mask,
                                 input int full_pct, input int min_delay, input int max_delay,
                                 input int abort_cycle, input int hold_at);
        logic [7:0] exp_q[$];
        int delay[MAX];
        int nlen, hdr, got_n, exp_wait, total_wait, wait_cnt, cur_delay;
        int last_event, last_wait, abort_at, hold_left, idx;
        bit exp_to, held, ended, wait_state;

        nlen = (int'(len) > MAX) ? MAX : int'(len);
        hdr  = skip ? 1 : 2;
        exp_q = {};
        if (!skip) exp_q.push_back(8'h55);
        exp_q.push_back(op);
        exp_wait = 0;
        exp_to   = 1'b0;
        for (int i = 0; i < nlen; i++) begin
            exp_q.push_back(d[8*i +: 8]);
            delay[i] = 0;
            if (mask[i]) begin
                delay[i] = $urandom_range(max_delay, min_delay);
                if (TO_EN && delay[i] > TO) begin
                    exp_to = 1'b1;
                    exp_wait += TO;
                    break;
                end
                exp_wait += delay[i];
            end
        end

        @(negedge clk);
        checkOutput("ready_idle", ready, 1);
        start = 1'b1; skip_synch = skip; opcode = op; data = d; data_len = len;
        wait_ack_after = mask; fifo_full = 1'b0; ack_received = 1'b0; abort = 1'b0;

        got_n = 0; total_wait = 0; wait_cnt = 0; cur_delay = 0; last_event = 0;
        last_wait = 0; abort_at = -1; hold_left = 0; held = 1'b0; ended = 1'b0;
        for (int cyc = 1; cyc <= 2000; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                start = 1'b0;
                skip_synch = 1'($urandom); opcode = 8'($urandom);
                data = {$urandom, $urandom, $urandom, $urandom};
                data_len = (AB+1)'($urandom); wait_ack_after = MAX'($urandom);
            end
            wait_state = waiting_for_ack;
            if (got_n == hold_at && !held) begin
                held = 1'b1;
                hold_left = 4;
            end
            if (hold_left > 0) begin
                fifo_full = 1'b1;
                hold_left--;
            end else begin
                fifo_full = ($urandom_range(99, 0) < full_pct);
            end
            if (wait_state) begin
                wait_cnt++;
                total_wait++;
                last_wait = cyc;
                if (wait_cnt == 1) begin
                    idx = got_n - 1 - hdr;
                    if (idx >= 0 && idx < nlen) begin
                        checkOutput("wait_mask", mask[idx], 1);
                        cur_delay = delay[idx];
                    end else begin
                        checkOutput("wait_idx", 0, 1);
                        cur_delay = 1;
                    end
                end
                ack_received = (wait_cnt == cur_delay);
                if (ack_received) last_event = cyc;
            end else begin
                wait_cnt = 0;
                ack_received = ($urandom_range(3, 0) == 0);
            end
            abort = (cyc == abort_cycle);
            #1;
            if (cyc == 1) begin
                checkOutput("ready_drop", ready, 0);
                checkOutput("bytes_clr", bytes_sent, 0);
            end
            if (done || error || timeout) begin
                checkOutput("done_err_excl", done & error, 0);
                checkOutput("ready_back", ready, 1);
                checkOutput("bytes_sent", bytes_sent, got_n);
                if (abort_at > 0) begin
                    checkOutput("abort_err", error, 1);
                    checkOutput("abort_done", done, 0);
                    checkOutput("abort_to", timeout, 0);
                    checkOutput("abort_lat", cyc, abort_at + 1);
                end else if (exp_to) begin
                    checkOutput("to_err", error, 1);
                    checkOutput("to_flag", timeout, 1);
                    checkOutput("to_done", done, 0);
                    checkOutput("to_bytes", got_n, exp_q.size());
                    checkOutput("to_wait", total_wait, exp_wait);
                    checkOutput("to_lat", cyc, last_wait + 1);
                end else begin
                    checkOutput("done", done, 1);
                    checkOutput("done_err", error, 0);
                    checkOutput("done_to", timeout, 0);
                    checkOutput("frame_bytes", got_n, exp_q.size());
                    checkOutput("ack_wait", total_wait, exp_wait);
                    checkOutput("done_lat", cyc, last_event + 1);
                end
                ended = 1'b1;
                break;
            end
            if (abort) begin
                checkOutput("abort_nowrite", fifo_wr_en, 0);
                abort_at = cyc;
            end
            if (fifo_wr_en && !fifo_full) begin
                if (got_n < exp_q.size()) checkOutput("byte", fifo_data, exp_q[got_n]);
                else checkOutput("extra_write", 1, 0);
                got_n++;
                last_event = cyc;
            end
        end
        if (!ended) checkOutput("frame_end_bound", 0, 1);
        @(negedge clk);
        abort = 1'b0; ack_received = 1'b0; fifo_full = 1'b0;
        #1;
        checkOutput("pulse_width", done | error | timeout, 0);
    endtask

    initial begin
        logic [8*MAX-1:0] rd;
        rst_n = 1'b0; start = 1'b0; skip_synch = 1'b0; abort = 1'b0; opcode = '0; data = '0;
        data_len = '0; wait_ack_after = '0; ack_received = 1'b0; fifo_full = 1'b0;
        #3;
        checkResetValues("rst");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("ready_pre_clk", ready, 0);
        @(negedge clk);
        checkOutput("ready_after_rel", ready, 1);

        // Directed frames
        applyStimulus(1'b0, 8'h04, '0, 0, '0, 0, 1, 1, -1, -1);
        rd = '0; rd[23:0] = 24'hC3B2A1;
        applyStimulus(1'b0, 8'h44, rd, 3, 16'h0002, 0, 5, 5, -1, -1);
        applyStimulus(1'b0, 8'h65, rd, 3, 16'h0000, 0, 1, 1, -1, 1);
        applyStimulus(1'b0, 8'h64, {$urandom, $urandom, $urandom, $urandom}, 4, '0, 0, 1, 1, 4, -1);
        applyStimulus(1'b1, 8'h24, {$urandom, $urandom, $urandom, $urandom}, MAX + 1, '0, 20, 1, 1, -1, -1);
`ifdef UPDI_FRAME_SEQ_ACK_TIMEOUT_EN
        applyStimulus(1'b0, 8'h20, {$urandom, $urandom, $urandom, $urandom}, 2, 16'h0001, 0, 100, 100, -1, -1);
`endif

        // Reset in the middle of a frame
        @(negedge clk);
        start = 1'b1; skip_synch = 1'b0; opcode = 8'h11; data_len = 4; wait_ack_after = '0;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkResetValues("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("midrst_nopulse", done | error | timeout, 0);
            checkOutput("midrst_ready", ready, 1);
        end

        // Randomized frames
        for (int n = 0; n < 40; n++) begin
            applyStimulus(1'($urandom), 8'($urandom), {$urandom, $urandom, $urandom, $urandom},
                          (AB+1)'(($urandom_range(9, 0) == 0) ? $urandom_range(31, 0) : $urandom_range(MAX + 1, 0)),
                          MAX'($urandom & $urandom), $urandom_range(40, 0), 1, 12,
                          ($urandom_range(3, 0) == 0) ? int'($urandom_range(30, 1)) : -1, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
